// File: rtl/seq_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// The next-state function builds the failure-function transition table.
package seq_pkg;

    localparam int unsigned MAX_PAT_LEN = 16;

    function automatic int unsigned state_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

    // Largest k <= len such that the first k pattern bits are a suffix of
    // (first e pattern bits, then x). Pattern bit len-1 is the first bit.
    function automatic int unsigned next_state(input logic [MAX_PAT_LEN-1:0] pattern,
                                               input int unsigned len,
                                               input int unsigned s,
                                               input logic x,
                                               input logic overlap);
        int unsigned e;
        logic [MAX_PAT_LEN:0] seq;
        logic ok;
        if (s > len) begin
            return 0;
        end
        e = (s == len && !overlap) ? 0 : s;
        seq = '0;
        for (int i = 0; i < MAX_PAT_LEN; i++) begin
            if (i < int'(e)) begin
                seq[i] = pattern[len-1-i];
            end
        end
        seq[e] = x;
        for (int k = MAX_PAT_LEN; k >= 1; k--) begin
            if (k <= int'(len) && k <= int'(e) + 1) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_PAT_LEN; i++) begin
                    if (i < k && pattern[len-1-i] != seq[int'(e)+1-k+i]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    return k;
                end
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/jk_reg.sv
// W-bit register of JK flip-flops with asynchronous active-low reset to zero.
module jk_reg #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] j,
    input  logic [W-1:0] k,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = (j & ~q_q) | (~k & q_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_detect_jk.sv
// Parametrised serial pattern detector: table-driven next state, JK state register,
// Mealy or Moore match flag and a saturating match counter.
module seq_detect_jk
    import seq_pkg::*;
#(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int unsigned        MOORE   = 0,
    parameter int unsigned        OVERLAP = 1,
    parameter int unsigned        CNT_W   = 8,
    localparam int unsigned       SW      = state_width(PAT_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             x,
    output logic             y,
    output logic [SW-1:0]    state,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [SW-1:0]    FULL    = SW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SW-1:0]    ns_tbl [2**SW][2];
    logic [SW-1:0]    state_q;
    logic [SW-1:0]    ns_raw;
    logic [SW-1:0]    nxt;
    logic [SW-1:0]    jx;
    logic [SW-1:0]    kx;
    logic             match;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Transition table resolved at elaboration; illegal encodings map to 0.
    for (genvar gs = 0; gs < 2**SW; gs++) begin : g_state
        for (genvar gx = 0; gx < 2; gx++) begin : g_bit
            localparam int unsigned NS = next_state(MAX_PAT_LEN'(PATTERN), PAT_LEN, gs,
                                                    1'(gx), OVERLAP != 0);
            assign ns_tbl[gs][gx] = SW'(NS);
        end
    end

    always_comb begin
        ns_raw = ns_tbl[state_q][x];
        nxt    = state_q;
        if (clr) begin
            nxt = '0;
        end else if (en) begin
            nxt = ns_raw;
        end
        // Holding (en=0) makes nxt equal q, so J=K=0 falls out of the excitation.
        jx    = nxt & ~state_q;
        kx    = ~nxt & state_q;
        match = en & ~clr & (ns_raw == FULL);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (match && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    jk_reg #(
        .W (SW)
    ) u_state_reg (
        .clk   (clk),
        .rst_n (rst),
        .j     (jx),
        .k     (kx),
        .q     (state_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        if (MOORE != 0) begin
            y = (state_q == FULL);
        end else begin
            y = rst & match;
        end
    end

    assign state     = state_q;
    assign match_cnt = cnt_q;

endmodule

// File: doc/seq_detect_jk.md
# seq_detect_jk

Parametrised serial pattern detector, the general successor of our fixed 3-state JK sequence machines. It takes one serial bit per enabled clock and flags every occurrence of a compile-time pattern. Pattern length, pattern value, Mealy/Moore output and overlapping/non-overlapping matching are all parameters. The state register is built from JK flip-flops with derived excitation; a saturating match counter is included. It sits between a serial input synchroniser and downstream control logic.

## Interface
- PAT_LEN, default 4: pattern length in bits; legal range 2..16.
- PATTERN, default 4'b1011: pattern. Bit PAT_LEN-1 is expected first on x.
- MOORE, default 0: 0 = Mealy output, 1 = Moore output.
- OVERLAP, default 1: 1 = overlapping matches allowed; 0 = matching restarts from empty after each match.
- CNT_W, default 8: width of the match counter.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  x is sampled only when en=1; otherwise the state holds.
- clr  input  1  synchronous clear of state and counter; has priority over en.
- x  input  1  serial data bit.
- y  output  1  match flag.
- state  output  SW  current state s (matched-prefix length), where SW = $clog2(PAT_LEN+1).
- match_cnt  output  CNT_W  number of matches; saturates at all-ones.

## Operation
- State s ∈ 0..PAT_LEN is the number of leading PATTERN bits currently matched. Encodings above PAT_LEN are illegal; if reached, the next state is 0.
- Effective state: e = 0 if (s==PAT_LEN and OVERLAP==0); otherwise e = s.
- Next state with en=1: the largest k ≤ PAT_LEN such that the first k pattern bits equal a suffix of (first e pattern bits, then x). Overlapping behaviour therefore follows standard failure-function transitions.
- The next-state table is computed at elaboration by a constant function. No runtime shift register is used.
- With en=0, s holds. With clr=1, s ← 0 and match_cnt ← 0.
- Match event: en=1, clr=0 and next state == PAT_LEN.
- Mealy mode: y = rst & en & ~clr & (next==PAT_LEN). This output is combinational from x and s.
- Moore mode: y = (s==PAT_LEN). It is registered, so it appears one cycle after the match bit.
- match_cnt increments by 1 on each match event and holds at 2^CNT_W−1.
- State flip-flops are JK. Per bit: J = next & ~q, K = ~next & q. When en=0, J=K=0.

## Timing
- Reset (rst=0, asynchronous): s=0, match_cnt=0, y=0 in both modes. The reset takes effect immediately, including mid-pattern.
- Mealy output latency: 0 cycles, valid in the same cycle as the last pattern bit. Moore output latency: 1 cycle.
- clr and a match bit in the same cycle: clr wins. No count is taken, and Mealy y=0.
- Counter saturated and a new match: y still asserts and the counter holds.
- en low between bits is transparent. The pattern may be spread over any number of enabled cycles.
- Moore mode with OVERLAP=1: a match immediately followed by another match keeps y high for consecutive cycles.

## Structure
- Package seq_pkg holds:
  - the constant function next_state(pattern, len, s, x, overlap);
  - the state-width helper;
  - localparams for the maximum PAT_LEN.
- Sub-module jk_reg (parameter W): a W-bit JK flip-flop register with asynchronous active-low reset to 0 and Q+ = J·~Q | ~K·Q. The top level holds the next-state and output logic, the excitation logic and the counter.

## Test plan
- Default parameters, OVERLAP=1, en=1, x = 1,0,1,1,0,1,1 → Mealy y high on bits 4 and 7; match_cnt=2; state after bit 7 = 4.
- Same stream with OVERLAP=0 → y high on bit 4 only; match_cnt=1; states after bits 4..7 are 4,0,1,1.
- MOORE=1, OVERLAP=1, same stream → y high in the cycles after bits 4 and 7; the y edge lags Mealy by exactly 1 clk.
- Pattern 1,0,1 split by en=0 gaps of 3 cycles, then final bit 1 → single match; state holds during the gaps.
- CNT_W=2, six back-to-back overlapping matches of PATTERN=2'b11 (x=1 continuous) → match_cnt stops at 3; y continues asserting.
- rst pulsed low asynchronously after x=1,0,1 (s=3), followed by x=1 → no match; state=1 after that bit. Also: clr together with the match bit gives y=0 and match_cnt=0.
